weight_addrgen_mp: RTL and testbench

Parametrised weight-RAM address generator for the conv engine. It drives NUM_PORTS read ports in parallel, one address per port per enabled cycle. Runtime configuration is latched on a start pulse; the block replaces the fixed two-port, compile-time-sized generator. It sits between the layer controller (start/done handshake) and the weight buffer read ports, and steps in lock-step with the MAC array through `enable`.

---
 rtl/weight_addrgen_mp.sv | 181 ++++++++++++++++++
 tb/tb_weight_addrgen_mp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_addrgen_mp.sv
// Multi-port weight-RAM address generator: walks k/o/g counters and issues NUM_PORTS addresses per enabled beat.
// Optional abort input is compiled in when WADDR_ABORT_EN is defined.
module weight_addrgen_mp #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned CNT_WIDTH  = 10
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [ADDR_WIDTH-1:0]             cfg_base,
   input  logic [CNT_WIDTH-1:0]              cfg_k_m1,
   input  logic [CNT_WIDTH-1:0]              cfg_pix_m1,
   input  logic [CNT_WIDTH-1:0]              cfg_grp_m1,
   input  logic                              enable,
`ifdef WADDR_ABORT_EN
   input  logic                              abort,
`endif
   output logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
   output logic                              addr_valid,
   output logic                              addr_last,
   output logic                              busy,
   output logic                              done
);

   localparam int unsigned BUS_WIDTH = NUM_PORTS * ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PORT_STEP = ADDR_WIDTH'(NUM_PORTS);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [CNT_WIDTH-1:0]   k_m1_q;
   logic [CNT_WIDTH-1:0]   pix_m1_q;
   logic [CNT_WIDTH-1:0]   grp_m1_q;
   logic [CNT_WIDTH-1:0]   k_cnt;
   logic [CNT_WIDTH-1:0]   o_cnt;
   logic [CNT_WIDTH-1:0]   g_cnt;
   logic [ADDR_WIDTH-1:0]  k_off;
   logic [ADDR_WIDTH-1:0]  grp_off;

   logic                   abort_c;
   logic                   k_last_c;
   logic                   o_last_c;
   logic                   g_last_c;
   logic                   run_last_c;
   logic [ADDR_WIDTH-1:0]  beat_base_c;
   logic [BUS_WIDTH-1:0]   beat_addr_c;

`ifdef WADDR_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   assign k_last_c   = (k_cnt == k_m1_q);
   assign o_last_c   = (o_cnt == pix_m1_q);
   assign g_last_c   = (g_cnt == grp_m1_q);
   assign run_last_c = k_last_c & o_last_c & g_last_c;

   // Per-port addresses for the current counter state; o does not contribute (weights reused per pixel).
   always_comb begin
      beat_base_c = base_q + grp_off + k_off;
      beat_addr_c = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         beat_addr_c[p*ADDR_WIDTH +: ADDR_WIDTH] = beat_base_c + ADDR_WIDTH'(p);
      end
   end

   // Control, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         base_q     <= '0;
         k_m1_q     <= '0;
         pix_m1_q   <= '0;
         grp_m1_q   <= '0;
         k_cnt      <= '0;
         o_cnt      <= '0;
         g_cnt      <= '0;
         k_off      <= '0;
         grp_off    <= '0;
         addr       <= '0;
         addr_valid <= 1'b0;
         addr_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               addr_valid <= 1'b0;
               addr_last  <= 1'b0;
               done       <= 1'b0;
               if (start) begin
                  base_q   <= cfg_base;
                  k_m1_q   <= cfg_k_m1;
                  pix_m1_q <= cfg_pix_m1;
                  grp_m1_q <= cfg_grp_m1;
                  k_cnt    <= '0;
                  o_cnt    <= '0;
                  g_cnt    <= '0;
                  k_off    <= '0;
                  grp_off  <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end

            RUN: begin
               if (abort_c) begin
                  k_cnt      <= '0;
                  o_cnt      <= '0;
                  g_cnt      <= '0;
                  k_off      <= '0;
                  grp_off    <= '0;
                  addr_valid <= 1'b0;
                  addr_last  <= 1'b0;
                  done       <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else if (enable) begin
                  addr       <= beat_addr_c;
                  addr_valid <= 1'b1;
                  addr_last  <= run_last_c;
                  done       <= run_last_c;
                  if (k_last_c) begin
                     k_cnt <= '0;
                     k_off <= '0;
                     if (o_last_c) begin
                        o_cnt <= '0;
                        if (g_last_c) begin
                           state <= DONE;
                        end else begin
                           g_cnt   <= g_cnt + CNT_ONE;
                           // k_off is (K-1)*NUM_PORTS here, so this adds K*NUM_PORTS.
                           grp_off <= grp_off + k_off + PORT_STEP;
                        end
                     end else begin
                        o_cnt <= o_cnt + CNT_ONE;
                     end
                  end else begin
                     k_cnt <= k_cnt + CNT_ONE;
                     k_off <= k_off + PORT_STEP;
                  end
               end else begin
                  addr_valid <= 1'b0;
                  addr_last  <= 1'b0;
                  done       <= 1'b0;
               end
            end

            DONE: begin
               k_cnt      <= '0;
               o_cnt      <= '0;
               g_cnt      <= '0;
               k_off      <= '0;
               grp_off    <= '0;
               addr_valid <= 1'b0;
               addr_last  <= 1'b0;
               done       <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               addr_valid <= 1'b0;
               addr_last  <= 1'b0;
               done       <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_addrgen_mp.sv
// Self-checking bench for weight_addrgen_mp: directed and random runs against a nested-loop address model.
module tb_weight_addrgen_mp;

   localparam int unsigned AW = 12;
   localparam int unsigned NP = 2;
   localparam int unsigned CW = 10;
   localparam int unsigned BW = AW * NP;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] cfg_base;
   logic [CW-1:0] cfg_k_m1;
   logic [CW-1:0] cfg_pix_m1;
   logic [CW-1:0] cfg_grp_m1;
   logic          enable;
`ifdef WADDR_ABORT_EN
   logic          abort;
`endif
   logic [BW-1:0] addr;
   logic          addr_valid;
   logic          addr_last;
   logic          busy;
   logic          done;

   int            total;
   int            bad;
   logic [BW-1:0] held;
   logic [BW-1:0] exp_q[$];

   weight_addrgen_mp #(
      .ADDR_WIDTH (AW),
      .NUM_PORTS  (NP),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cfg_base   (cfg_base),
      .cfg_k_m1   (cfg_k_m1),
      .cfg_pix_m1 (cfg_pix_m1),
      .cfg_grp_m1 (cfg_grp_m1),
      .enable     (enable),
`ifdef WADDR_ABORT_EN
      .abort      (abort),
`endif
      .addr       (addr),
      .addr_valid (addr_valid),
      .addr_last  (addr_last),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected beats in issue order: every (g, o, k) triple, address ignores o.
   task automatic build_beats(input int base, input int km, input int pm, input int gm);
      logic [BW-1:0] v;
      exp_q.delete();
      for (int gi = 0; gi <= gm; gi++)
         for (int oi = 0; oi <= pm; oi++)
            for (int ki = 0; ki <= km; ki++) begin
               v = '0;
               for (int p = 0; p < NP; p++)
                  v[p*AW +: AW] = AW'(base + gi*(km+1)*NP + ki*NP + p);
               exp_q.push_back(v);
            end
   endtask

   task automatic run(input string name, input int base, input int km, input int pm, input int gm,
                      input int stall_pct, input int stall_after, input bit junk,
                      input int reset_at, input int abort_at);
      int idx;
      int stall_left;
      int cyc;
      bit en;
      bit fin;
      bit cut;
      bit is_last;
      build_beats(base, km, pm, gm);
      cfg_base   = AW'(base);
      cfg_k_m1   = CW'(km);
      cfg_pix_m1 = CW'(pm);
      cfg_grp_m1 = CW'(gm);
      start      = 1'b1;
      enable     = 1'($urandom_range(1));
      @(negedge clk);
      start = 1'b0;
      chk({name, ":busy_up"}, 64'(busy), 64'(1));
      chk({name, ":valid_first"}, 64'(addr_valid), 64'(0));
      chk({name, ":addr_held_first"}, 64'(addr), 64'(held));
      idx = 0; stall_left = 3; cyc = 0; fin = 0; cut = 0;
      while (!fin) begin
         if (stall_after >= 0 && idx == stall_after && stall_left > 0) begin
            en = 1'b0;
            stall_left--;
         end else begin
            en = ($urandom_range(99) >= stall_pct);
         end
         enable = en;
         if (junk) begin
            start      = 1'($urandom_range(1));
            cfg_base   = AW'($urandom);
            cfg_k_m1   = CW'($urandom);
            cfg_pix_m1 = CW'($urandom);
            cfg_grp_m1 = CW'($urandom);
         end
         @(negedge clk);
         if (en) begin
            held = exp_q[idx];
            idx++;
         end
         is_last = en && (idx == exp_q.size());
         chk({name, ":valid"}, 64'(addr_valid), 64'(en));
         chk({name, ":addr"}, 64'(addr), 64'(held));
         chk({name, ":last"}, 64'(addr_last), 64'(is_last));
         chk({name, ":done"}, 64'(done), 64'(is_last));
         chk({name, ":busy"}, 64'(busy), 64'(1));
         cyc++;
         if (is_last) begin
            fin = 1;
         end else if (en && idx == reset_at) begin
            reset = 1'b1;
            #1;
            held = '0;
            chk({name, ":rst_addr"}, 64'(addr), 64'(0));
            chk({name, ":rst_valid"}, 64'(addr_valid), 64'(0));
            chk({name, ":rst_last"}, 64'(addr_last), 64'(0));
            chk({name, ":rst_busy"}, 64'(busy), 64'(0));
            chk({name, ":rst_done"}, 64'(done), 64'(0));
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk({name, ":post_rst_done"}, 64'(done), 64'(0));
            chk({name, ":post_rst_busy"}, 64'(busy), 64'(0));
            fin = 1; cut = 1;
         end else if (en && idx == abort_at) begin
`ifdef WADDR_ABORT_EN
            abort  = 1'b1;
            enable = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            chk({name, ":abort_valid"}, 64'(addr_valid), 64'(0));
            chk({name, ":abort_done"}, 64'(done), 64'(0));
            chk({name, ":abort_busy"}, 64'(busy), 64'(0));
            chk({name, ":abort_addr"}, 64'(addr), 64'(held));
            @(negedge clk);
            chk({name, ":abort_valid2"}, 64'(addr_valid), 64'(0));
            chk({name, ":abort_done2"}, 64'(done), 64'(0));
`endif
            fin = 1; cut = 1;
         end else if (cyc > 5000) begin
            chk({name, ":timeout_beats"}, 64'(idx), 64'(exp_q.size()));
            fin = 1; cut = 1;
         end
      end
      if (!cut) begin
         start  = 1'b0;
         enable = 1'($urandom_range(1));
         @(negedge clk);
         chk({name, ":busy_drop"}, 64'(busy), 64'(0));
         chk({name, ":valid_end"}, 64'(addr_valid), 64'(0));
         chk({name, ":done_end"}, 64'(done), 64'(0));
         chk({name, ":beats"}, 64'(idx), 64'(exp_q.size()));
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      start = 1'b0;
      enable = 1'b0;
      cfg_base = '0;
      cfg_k_m1 = '0;
      cfg_pix_m1 = '0;
      cfg_grp_m1 = '0;
`ifdef WADDR_ABORT_EN
      abort = 1'b0;
`endif
      held = '0;
      #1;
      chk("reset:addr", 64'(addr), 64'(0));
      chk("reset:valid", 64'(addr_valid), 64'(0));
      chk("reset:last", 64'(addr_last), 64'(0));
      chk("reset:busy", 64'(busy), 64'(0));
      chk("reset:done", 64'(done), 64'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run("basic",      0,     3, 1, 1, 0,  -1, 1'b0, -1, -1);
      run("stall",      0,     3, 1, 1, 0,   5, 1'b0, -1, -1);
      run("wrap",       'hFFC, 2, 0, 0, 0,  -1, 1'b0, -1, -1);
      run("ign_start",  5,     2, 2, 1, 0,  -1, 1'b1, -1, -1);
      run("back2back",  100,   1, 1, 0, 20, -1, 1'b1, -1, -1);
      run("reset_mid",  0,     3, 1, 1, 0,  -1, 1'b0,  7, -1);
      run("after_rst",  0,     3, 1, 1, 0,  -1, 1'b0, -1, -1);
      run("all_zero",   'h7A5, 0, 0, 0, 0,  -1, 1'b0, -1, -1);
`ifdef WADDR_ABORT_EN
      run("abort",      0,     3, 1, 1, 0,  -1, 1'b0, -1,  4);
      run("after_abt",  0,     3, 1, 1, 0,  -1, 1'b0, -1, -1);
`endif
      for (int r = 0; r < 8; r++) begin
         run("rand", int'($urandom_range(4095)), int'($urandom_range(5)),
             int'($urandom_range(3)), int'($urandom_range(3)), 30, -1, 1'b1, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
